// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register and its statistics counters.
package pipe_pkg;

    // Held-beat state. The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // Default width of each statistics counter.
    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stage statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with an optional 2-entry skid buffer, flush and
// stall/flush statistics.
//
// Handshake: a beat moves upstream on a cycle where in_valid && in_ready and
// downstream where out_valid && out_ready. Once out_valid is raised, out_data
// stays stable until the beat drains or a flush/reset removes it; out_valid
// never depends on out_ready. Flush and reset win over any transfer in the
// same cycle, but a downstream handshake in a flush cycle still counts as
// consumed.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 96,
    parameter int                SKID     = 1,
    parameter int                CNT_W    = CNT_W_DEFAULT,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [1:0]        state_dbg
);

    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic [DATA_W-1:0] out_data_q;
    logic              accept;
    logic              drain;

    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_data_q;
    assign occupancy = state_q;
    assign state_dbg = state_q;

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_q;
            logic              in_ready_q;
            logic              load_out;
            logic              load_skid;
            logic              move_skid;

            // Next state and data-path enables for the two-entry buffer.
            always_comb begin
                state_d   = state_q;
                load_out  = 1'b0;
                load_skid = 1'b0;
                move_skid = 1'b0;
                if (flush) begin
                    state_d = EMPTY;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (accept) begin
                                state_d  = ONE;
                                load_out = 1'b1;
                            end
                        end
                        ONE: begin
                            if (accept && drain) begin
                                load_out = 1'b1;
                            end else if (accept) begin
                                state_d   = TWO;
                                load_skid = 1'b1;
                            end else if (drain) begin
                                state_d = EMPTY;
                            end
                        end
                        TWO: begin
                            if (drain) begin
                                state_d   = ONE;
                                move_skid = 1'b1;
                            end
                        end
                        default: state_d = EMPTY;
                    endcase
                end
            end

            // State, output/skid registers and the registered ready flag.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q    <= EMPTY;
                    out_data_q <= RST_DATA;
                    skid_q     <= '0;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    in_ready_q <= (state_d != TWO);
                    if (load_out) begin
                        out_data_q <= in_data;
                    end else if (move_skid) begin
                        out_data_q <= skid_q;
                    end
                    if (load_skid) begin
                        skid_q <= in_data;
                    end
                end
            end

            // Ready comes from a flop; it is only masked while reset is held.
            assign in_ready = in_ready_q && !rst;
        end else begin : g_single
            logic load_out;

            // Next state for the single-register variant.
            always_comb begin
                state_d  = state_q;
                load_out = 1'b0;
                if (flush) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    state_d  = ONE;
                    load_out = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end

            // State and output register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q    <= EMPTY;
                    out_data_q <= RST_DATA;
                end else begin
                    state_q <= state_d;
                    if (load_out) begin
                        out_data_q <= in_data;
                    end
                end
            end

            // Full throughput without a skid entry needs ready to follow out_ready.
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush && (state_q != EMPTY)),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, single register, 4-bit
// counters) share one stimulus bus; the instance selected by sel is scored
// against a queue model of the held beats.
module tb_pipe_stage_reg;

  localparam logic [95:0] RST4 = 96'h0000_00a5_0000_0000_dead_beef;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [95:0] in_data;
  logic        out_ready;
  logic        flush;
  logic [1:0]  sel;

  logic        ir0, ov0, ir1, ov1, ir4, ov4;
  logic [95:0] od0, od1, od4;
  logic [1:0]  occ0, occ1, occ4, sd0, sd1, sd4;
  logic [15:0] st0, fc0, st1, fc1;
  logic [3:0]  st4, fc4;

  logic        m_ir, m_ov;
  logic [95:0] m_od;
  logic [1:0]  m_occ;
  logic [15:0] m_st, m_fc;

  logic [95:0] exp_q[$];
  logic [95:0] hold;
  logic [95:0] rst_data;
  logic        m_skid;
  int          cnt_max;
  int          exp_stall;
  int          exp_flush;
  logic        checking;
  int          n_checks;
  int          n_fail;

  pipe_stage_reg #(.DATA_W(96), .SKID(1), .CNT_W(16), .RST_DATA(96'h0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_ready(out_ready), .flush(flush),
    .occupancy(occ0), .stall_cnt(st0), .flush_cnt(fc0), .state_dbg(sd0));

  pipe_stage_reg #(.DATA_W(96), .SKID(0), .CNT_W(16), .RST_DATA(96'h0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(out_ready), .flush(flush),
    .occupancy(occ1), .stall_cnt(st1), .flush_cnt(fc1), .state_dbg(sd1));

  pipe_stage_reg #(.DATA_W(96), .SKID(1), .CNT_W(4), .RST_DATA(RST4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_ready(out_ready), .flush(flush),
    .occupancy(occ4), .stall_cnt(st4), .flush_cnt(fc4), .state_dbg(sd4));

  // Clock and per-instance model knobs.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_skid   = (sel != 2'd1);
  assign cnt_max  = (sel == 2'd2) ? 15 : 65535;
  assign rst_data = (sel == 2'd2) ? RST4 : 96'h0;

  always_comb begin
    case (sel)
      2'd0: begin
        m_ir = ir0; m_ov = ov0; m_od = od0; m_occ = occ0; m_st = st0; m_fc = fc0;
      end
      2'd1: begin
        m_ir = ir1; m_ov = ov1; m_od = od1; m_occ = occ1; m_st = st1; m_fc = fc1;
      end
      default: begin
        m_ir = ir4; m_ov = ov4; m_od = od4; m_occ = occ4;
        m_st = {12'd0, st4}; m_fc = {12'd0, fc4};
      end
    endcase
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (sel=%0d t=%0t): got %0h expected %0h", name, sel, $time, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, then record its effect in the model
  // (accepted beats queued, flush/reset discards, counter expectations).
  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input logic iv, input logic [95:0] d, input logic ordy,
                       input logic fl, input logic r);
    int   sz;
    logic rdy;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    sz  = exp_q.size();
    rdy = m_skid ? (sz < 2) : (sz == 0 || ordy);
    @(negedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      exp_stall = 0;
      exp_flush = 0;
      hold      = rst_data;
      checking  = 1'b1;
    end else begin
      if (sz > 0 && !ordy && exp_stall < cnt_max) exp_stall++;
      if (fl && sz > 0 && exp_flush < cnt_max) exp_flush++;
      if (fl) exp_q.delete();
      else if (iv && rdy) exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(0, 99) < 70, {$urandom, $urandom, $urandom},
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4,
            $urandom_range(0, 499) == 0);
    end
  endtask

  // Monitor: compare the selected instance against the model mid-cycle and
  // retire the head beat on a downstream handshake.
  always @(negedge clk) begin
    int sz;
    if (checking && !rst) begin
      sz = exp_q.size();
      check("out_valid", 96'(m_ov), 96'(sz > 0));
      check("occupancy", 96'(m_occ), 96'(sz));
      check("in_ready", 96'(m_ir), 96'(m_skid ? (sz < 2) : (sz == 0 || out_ready)));
      check("stall_cnt", 96'(m_st), 96'(exp_stall));
      check("flush_cnt", 96'(m_fc), 96'(exp_flush));
      if (sz > 0) begin
        check("out_data", m_od, exp_q[0]);
        hold = exp_q[0];
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        check("held_data", m_od, hold);
      end
    end
  end

  // Stimulus sequence.
  initial begin
    n_checks = 0; n_fail = 0; checking = 1'b0;
    exp_stall = 0; exp_flush = 0; hold = '0;
    sel = 2'd0; rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk);
    #1;

    // Skid instance: reset state.
    cycle(0, 96'h0, 1, 0, 1);
    check("ready_in_reset", 96'(m_ir), 96'(0));
    cycle(0, 96'h0, 1, 0, 1);
    cycle(0, 96'h0, 1, 0, 0);
    check("rst_valid", 96'(m_ov), 96'(0));
    check("rst_occ", 96'(m_occ), 96'(0));
    check("rst_data", m_od, 96'h0);
    check("rst_ready", 96'(m_ir), 96'(1));

    // Three beats against a blocked sink, then drain.
    cycle(1, 96'h1, 0, 0, 0);
    check("a_occ", 96'(m_occ), 96'(1));
    cycle(1, 96'h2, 0, 0, 0);
    check("b_occ", 96'(m_occ), 96'(2));
    check("b_ready", 96'(m_ir), 96'(0));
    check("b_data", m_od, 96'h1);
    cycle(1, 96'h3, 0, 0, 0);
    check("c_held_occ", 96'(m_occ), 96'(2));
    check("c_stall", 96'(m_st), 96'(2));
    cycle(1, 96'h3, 1, 0, 0);
    check("drain1_data", m_od, 96'h2);
    check("drain1_ready", 96'(m_ir), 96'(1));
    cycle(1, 96'h3, 1, 0, 0);
    check("drain2_data", m_od, 96'h3);
    cycle(0, 96'h0, 1, 0, 0);
    check("drain3_occ", 96'(m_occ), 96'(0));
    check("drain3_hold", m_od, 96'h3);

    // Flush while full with a new beat offered.
    cycle(1, 96'h1, 0, 0, 0);
    cycle(1, 96'h2, 0, 0, 0);
    cycle(1, 96'h4, 0, 1, 0);
    check("flush_valid", 96'(m_ov), 96'(0));
    check("flush_occ", 96'(m_occ), 96'(0));
    check("flush_cnt1", 96'(m_fc), 96'(1));
    check("flush_hold", m_od, 96'h1);
    for (int i = 0; i < 3; i++) cycle(0, 96'h0, 1, 0, 0);

    run_random(4000);

    // Single-register instance.
    sel = 2'd1;
    cycle(0, 96'h0, 1, 0, 1);
    cycle(0, 96'h0, 1, 0, 0);
    cycle(1, 96'h55, 0, 0, 0);
    check("s0_full_ready", 96'(m_ir), 96'(0));
    out_ready = 1'b1;
    #1;
    check("s0_comb_ready_hi", 96'(m_ir), 96'(1));
    out_ready = 1'b0;
    #1;
    check("s0_comb_ready_lo", 96'(m_ir), 96'(0));
    begin
      int v;
      int cyc;
      logic acc;
      v = 0;
      cyc = 0;
      while (v < 10 && cyc < 100) begin
        acc = (exp_q.size() == 0) || (cyc % 2 == 0);
        cycle(1, 96'(v), cyc % 2 == 0, 0, 0);
        if (acc) v++;
        cyc++;
      end
      check("s0_stream_done", 96'(v), 96'(10));
    end
    cycle(0, 96'h0, 1, 0, 0);
    cycle(0, 96'h0, 1, 0, 0);
    check("s0_empty", 96'(m_occ), 96'(0));

    run_random(3000);

    // 4-bit counter instance: saturation and reset mid-stall.
    sel = 2'd2;
    cycle(0, 96'h0, 1, 0, 1);
    cycle(0, 96'h0, 1, 0, 0);
    check("c4_rst_data", m_od, RST4);
    cycle(1, 96'h7, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 96'h0, 0, 0, 0);
    check("c4_stall_sat", 96'(m_st), 96'(15));
    cycle(0, 96'h0, 0, 0, 0);
    check("c4_stall_hold", 96'(m_st), 96'(15));
    cycle(0, 96'h0, 0, 1, 1);
    check("c4_rst_stall", 96'(m_st), 96'(0));
    check("c4_rst_flush", 96'(m_fc), 96'(0));
    check("c4_rst_valid", 96'(m_ov), 96'(0));
    check("c4_rst_out", m_od, RST4);

    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 96, width of the payload (pc + alu_out + ld_data of a W stage).
REQ-002 Parameter SKID, default 1, where 1 selects a 2-entry skid buffer and 0 selects a single register.
REQ-003 Parameter CNT_W, default 16, width of each statistics counter.
REQ-004 Parameter RST_DATA, default 0, value loaded into out_data by reset.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  upstream beat present.
REQ-008 in_data  in  DATA_W  upstream payload.
REQ-009 in_ready  out  1  stage accepts a beat this cycle.
REQ-010 out_valid  out  1  downstream beat present.
REQ-011 out_data  out  DATA_W  downstream payload.
REQ-012 out_ready  in  1  downstream accepts a beat this cycle.
REQ-013 flush  in  1  discard all held beats (branch mispredict or trap).
REQ-014 occupancy  out  2  number of held beats, 0..2.
REQ-015 stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
REQ-016 flush_cnt  out  CNT_W  flush cycles that discarded at least one beat.

Function
REQ-017 The block SHALL transfer a beat upstream when in_valid&&in_ready, and downstream when out_valid&&out_ready.
REQ-018 The block SHALL deliver beats in FIFO order with no duplication or loss except by flush.
REQ-019 With SKID=1, the state SHALL be one of EMPTY, ONE, TWO, with occupancy equal to 0, 1 or 2 respectively.
REQ-020 With SKID=1, in_ready SHALL equal (state!=TWO) and SHALL be driven from a register, with no combinational path from out_ready.
REQ-021 With SKID=1, the state transitions SHALL be: EMPTY->ONE on accept; ONE->TWO on accept with no drain; ONE->EMPTY on drain with no accept; ONE->ONE on accept with drain; TWO->ONE on drain (no accept possible).
REQ-022 With SKID=0, the state SHALL be EMPTY/ONE only, in_ready SHALL equal !out_valid||out_ready (combinational), and occupancy SHALL never exceed 1.
REQ-023 Latency SHALL be 1 cycle: a beat accepted at edge N appears on out_data/out_valid after edge N when occupancy was 0, or when occupancy was 1 and a drain occurred at the same edge.
REQ-024 In state TWO, out_data SHALL present the older beat; after it drains, the skid beat SHALL move to the output register at that edge.
REQ-025 Flush SHALL have priority over every transfer: at the flush edge the state SHALL go to EMPTY and out_valid to 0, and any beat accepted in that cycle SHALL be dropped.
REQ-026 A downstream handshake in a flush cycle SHALL still count as consumed by downstream, and the block SHALL NOT re-present that beat.
REQ-027 out_data SHALL hold its last value whenever out_valid=0, including after a flush; only valid bits are cleared.
REQ-028 stall_cnt SHALL increment by 1 each cycle with out_valid&&!out_ready and SHALL saturate at 2^CNT_W-1.
REQ-029 flush_cnt SHALL increment when flush=1 with occupancy>0 and SHALL saturate at 2^CNT_W-1.
REQ-030 When out_ready=1 continuously and in_valid=1 continuously, throughput SHALL be 1 beat per cycle in both modes.

Reset
REQ-031 At the reset edge: state=EMPTY, out_valid=0, occupancy=0, out_data=RST_DATA, skid register=0, stall_cnt=0, flush_cnt=0.
REQ-032 With SKID=1, in_ready SHALL be 1 from the first cycle after reset; during reset cycles it SHALL be 0.
REQ-033 Reset mid-operation SHALL discard all held beats without incrementing flush_cnt, and reset SHALL dominate flush.

Structure
REQ-034 Shared package pipe_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and the default CNT_W constant.
REQ-035 Each statistics counter SHALL be an instance of sub-module sat_counter, parametrised by width, with inputs clk, rst, inc and output count.
REQ-036 The SKID=0 variant SHALL be selected by a generate branch inside the same module, not by a separate module.

Verification
REQ-037 SKID=1: beats A=0x1, B=0x2, C=0x3 sent on consecutive cycles with out_ready=0 -> after B, occupancy=2 and in_ready=0; C is held off; out_data=0x1; stall_cnt increments each cycle.
REQ-038 Then out_ready=1 for 3 cycles -> outputs 0x1, 0x2, 0x3 in order; in_ready returns to 1 one cycle after the first drain.
REQ-039 occupancy=2 plus flush=1 together with in_valid=1 (D=0x4) -> next cycle out_valid=0, occupancy=0, flush_cnt=1, D never appears; out_data still 0x1.
REQ-040 SKID=0: streaming 0..9 with out_ready toggling 1,0,1,0 -> no loss or duplication, occupancy<=1, in_ready tracks out_ready combinationally when full.
REQ-041 CNT_W=4: out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and holds; rst=1 mid-stall -> all counters 0, out_data=RST_DATA.
REQ-042 Random valid/ready/flush for 10k cycles vs scoreboard model -> order preserved and counter values match the model.
